// File: rtl/sap1_control_sequencer.sv
// rtl/sap1_control_sequencer.sv - SAP-1 hardwired control unit: six-state ring counter, opcode decode, halt latch.
// Optional: define SAP1_CU_VAR_CYCLE_EN for variable-length machine cycles.
module sap1_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] OPCODE,
    output logic       CP,
    output logic       EP,
    output logic       LM,
    output logic       CE,
    output logic       LI,
    output logic       EI,
    output logic       LA,
    output logic       EA,
    output logic       SU,
    output logic       EU,
    output logic       LB,
    output logic       LO,
    output logic [5:0] T_STATE,
    output logic       HALTED
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state;
    t_state_e state_nxt;
    logic     halted_q;

    always_comb begin
        state_nxt = T1;
        case (state)
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: state_nxt = T4;
`ifdef SAP1_CU_VAR_CYCLE_EN
            // OUT and NOP are done after T4; HLT still steps to T5 where it parks.
            T4: begin
                if (OPCODE == OP_LDA || OPCODE == OP_ADD ||
                    OPCODE == OP_SUB || OPCODE == OP_HLT)
                    state_nxt = T5;
                else
                    state_nxt = T1;
            end
            T5: state_nxt = (OPCODE == OP_LDA) ? T1 : T6;
`else
            T4: state_nxt = T5;
            T5: state_nxt = T6;
`endif
            T6: state_nxt = T1;
            default: state_nxt = T1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= T1;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            state <= state_nxt;
            if (state == T4 && OPCODE == OP_HLT)
                halted_q <= 1'b1;
        end
    end

    // Decode is gated by CLR and the halt latch so the datapath sees a quiet bus.
    always_comb begin
        CP = 1'b0;
        EP = 1'b0;
        LM = 1'b0;
        CE = 1'b0;
        LI = 1'b0;
        EI = 1'b0;
        LA = 1'b0;
        EA = 1'b0;
        SU = 1'b0;
        EU = 1'b0;
        LB = 1'b0;
        LO = 1'b0;
        if (!CLR && !halted_q) begin
            case (state)
                T1: begin
                    EP = 1'b1;
                    LM = 1'b1;
                end
                T2: CP = 1'b1;
                T3: begin
                    CE = 1'b1;
                    LI = 1'b1;
                end
                T4: begin
                    if (OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        EI = 1'b1;
                        LM = 1'b1;
                    end else if (OPCODE == OP_OUT) begin
                        EA = 1'b1;
                        LO = 1'b1;
                    end
                end
                T5: begin
                    if (OPCODE == OP_LDA) begin
                        CE = 1'b1;
                        LA = 1'b1;
                    end else if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        CE = 1'b1;
                        LB = 1'b1;
                    end
                end
                T6: begin
                    if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
                        EU = 1'b1;
                        LA = 1'b1;
                        SU = (OPCODE == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign T_STATE = state;
    assign HALTED  = halted_q;

endmodule
